// File: rtl/alu_result_drain_if.sv
// Handshake bundle between the ALU result producer, the drain buffer and the
// 32-bit writeback datapath consumer.
interface alu_result_drain_if;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_result;
  logic        in_zero;
  logic [3:0]  in_op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_hi;
  logic        out_last;
  logic        out_zero;

  // Environment side: produces results and consumes beats.
  modport master (
    output in_valid, in_result, in_zero, in_op, out_ready,
    input  in_ready, out_valid, out_data, out_hi, out_last, out_zero
  );

  // Drain buffer side.
  modport slave (
    input  in_valid, in_result, in_zero, in_op, out_ready,
    output in_ready, out_valid, out_data, out_hi, out_last, out_zero
  );
endinterface

// File: rtl/alu_result_drain.sv
// Buffers 64-bit ALU results and drains them as 32-bit beats: multiply and
// divide results go out LO then HI, everything else as a single LO beat.
module alu_result_drain #(
  parameter  int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic               clock,
  input  logic               clear,
  alu_result_drain_if.slave  bus,
  output logic [PTR_W:0]     count,
  output logic               dbg_beat
);

  typedef enum logic { BEAT_LO = 1'b0, BEAT_HI = 1'b1 } beat_e;

  localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);
  localparam logic [3:0] OP_MUL = 4'b0111;
  localparam logic [3:0] OP_DIV = 4'b1010;

  logic [63:0] mem_result [DEPTH];
  logic        mem_zero   [DEPTH];
  logic [3:0]  mem_op     [DEPTH];

  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  beat_e            beat;

  logic        push;
  logic        pop;
  logic        xfer;
  logic        head_wide;
  logic [63:0] head_result;
  logic        head_zero;
  logic [3:0]  head_op;

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid never waits on ready, and a presented beat holds stable
  // until it is accepted. in_ready depends only on count, so a full buffer
  // refuses a push even when a pop happens in the same cycle.
  assign bus.in_ready  = (count != FULL);
  assign bus.out_valid = (count != '0);

  assign push = bus.in_valid && bus.in_ready;
  assign xfer = bus.out_valid && bus.out_ready;

  assign head_result = mem_result[rptr];
  assign head_zero   = mem_zero[rptr];
  assign head_op     = mem_op[rptr];
  assign head_wide   = (head_op == OP_MUL) || (head_op == OP_DIV);

  // A wide head stays put while its LO beat goes out; the HI beat pops it.
  assign pop = xfer && !(head_wide && (beat == BEAT_LO));

  assign dbg_beat = beat;

  always_comb begin
    bus.out_data = '0;
    bus.out_hi   = 1'b0;
    bus.out_last = 1'b0;
    bus.out_zero = 1'b0;
    if (bus.out_valid) begin
      bus.out_data = (beat == BEAT_HI) ? head_result[63:32] : head_result[31:0];
      bus.out_hi   = (beat == BEAT_HI);
      bus.out_last = !head_wide || (beat == BEAT_HI);
      bus.out_zero = head_zero;
    end
  end

  // Storage is not reset; entries are only read once count says they are valid.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_result[wptr] <= bus.in_result;
      mem_zero[wptr]   <= bus.in_zero;
      mem_op[wptr]     <= bus.in_op;
    end
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      beat  <= BEAT_LO;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (xfer) begin
        beat <= (head_wide && (beat == BEAT_LO)) ? BEAT_HI : BEAT_LO;
      end
    end
  end

endmodule

// File: tb/tb_alu_result_drain.sv
// Directed bench for alu_result_drain (DEPTH=2): reset, single/two-beat drain,
// backpressure when full, push/pop streaming across wrap, reset mid-result, zero flag.
module tb_alu_result_drain;

  localparam int DEPTH = 2;
  localparam int PTR_W = $clog2(DEPTH);

  logic             clock;
  logic             clear;
  logic [PTR_W:0]   count;
  logic             dbg_beat;
  int               pass_cnt;
  int               total_cnt;

  alu_result_drain_if bus ();

  alu_result_drain #(.DEPTH(DEPTH)) dut (
    .clock    (clock),
    .clear    (clear),
    .bus      (bus),
    .count    (count),
    .dbg_beat (dbg_beat)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // One cycle: land 1 time unit after the rising edge, where outputs are settled.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_push(input logic [3:0] op, input logic [63:0] res, input logic z);
    bus.in_valid  = 1'b1;
    bus.in_op     = op;
    bus.in_result = res;
    bus.in_zero   = z;
  endtask

  task automatic drive_idle();
    bus.in_valid  = 1'b0;
    bus.in_op     = 4'hx;
    bus.in_result = 64'h0BAD_0BAD_0BAD_0BAD;
    bus.in_zero   = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    clear = 1'b1;
    drive_idle();
    bus.out_ready = 1'b0;
    step();
    step();
    total_cnt++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); else pass_cnt++;
    total_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); else pass_cnt++;
    total_cnt++; if (bus.out_data !== 32'h0) $display("FAIL reset_out_data got=%h exp=0", bus.out_data); else pass_cnt++;
    total_cnt++; if ({bus.out_hi, bus.out_last, bus.out_zero} !== 3'b000)
      $display("FAIL reset_flags got=%b exp=000", {bus.out_hi, bus.out_last, bus.out_zero}); else pass_cnt++;
    total_cnt++; if (count !== '0) $display("FAIL reset_count got=%0d exp=0", count); else pass_cnt++;
    total_cnt++; if (dbg_beat !== 1'b0) $display("FAIL reset_beat got=%b exp=0", dbg_beat); else pass_cnt++;
    clear = 1'b0;
    step();
  endtask

  task automatic test_single_beat();
    bus.out_ready = 1'b1;
    drive_push(4'b0000, 64'h0000_0000_0000_0005, 1'b0);
    step();
    drive_idle();
    total_cnt++; if (bus.out_valid !== 1'b1) $display("FAIL add_valid got=%b exp=1", bus.out_valid); else pass_cnt++;
    total_cnt++; if (bus.out_data !== 32'h5) $display("FAIL add_data got=%h exp=5", bus.out_data); else pass_cnt++;
    total_cnt++; if ({bus.out_hi, bus.out_last} !== 2'b01) $display("FAIL add_hi_last got=%b exp=01", {bus.out_hi, bus.out_last}); else pass_cnt++;
    total_cnt++; if (count !== 2'd1) $display("FAIL add_count got=%0d exp=1", count); else pass_cnt++;
    step();
    total_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL add_drained got=%b exp=0", bus.out_valid); else pass_cnt++;
    total_cnt++; if (count !== 2'd0) $display("FAIL add_count_end got=%0d exp=0", count); else pass_cnt++;
    // Undefined opcode is narrow: only the LO half leaves.
    drive_push(4'b1111, 64'hFFFF_0000_1234_5678, 1'b0);
    step();
    drive_idle();
    total_cnt++; if (bus.out_data !== 32'h1234_5678) $display("FAIL undef_data got=%h exp=12345678", bus.out_data); else pass_cnt++;
    total_cnt++; if ({bus.out_hi, bus.out_last} !== 2'b01) $display("FAIL undef_hi_last got=%b exp=01", {bus.out_hi, bus.out_last}); else pass_cnt++;
    step();
    total_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL undef_one_beat got=%b exp=0", bus.out_valid); else pass_cnt++;
  endtask

  task automatic test_multiply();
    bus.out_ready = 1'b1;
    drive_push(4'b0111, 64'h0000_0001_8000_0000, 1'b0);
    step();
    drive_idle();
    total_cnt++; if (bus.out_data !== 32'h8000_0000) $display("FAIL mul_lo_data got=%h exp=80000000", bus.out_data); else pass_cnt++;
    total_cnt++; if ({bus.out_hi, bus.out_last} !== 2'b00) $display("FAIL mul_lo_flags got=%b exp=00", {bus.out_hi, bus.out_last}); else pass_cnt++;
    step();
    total_cnt++; if (bus.out_data !== 32'h0000_0001) $display("FAIL mul_hi_data got=%h exp=00000001", bus.out_data); else pass_cnt++;
    total_cnt++; if ({bus.out_hi, bus.out_last} !== 2'b11) $display("FAIL mul_hi_flags got=%b exp=11", {bus.out_hi, bus.out_last}); else pass_cnt++;
    total_cnt++; if (count !== 2'd1) $display("FAIL mul_count_mid got=%0d exp=1", count); else pass_cnt++;
    step();
    total_cnt++; if (count !== 2'd0) $display("FAIL mul_count_end got=%0d exp=0", count); else pass_cnt++;
    total_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL mul_drained got=%b exp=0", bus.out_valid); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    drive_push(4'b1010, 64'h0000_0003_0000_0007, 1'b0);
    step();
    drive_push(4'b0011, 64'h0, 1'b1);
    step();
    total_cnt++; if (bus.in_ready !== 1'b0) $display("FAIL full_in_ready got=%b exp=0", bus.in_ready); else pass_cnt++;
    total_cnt++; if (count !== 2'd2) $display("FAIL full_count got=%0d exp=2", count); else pass_cnt++;
    drive_push(4'b0000, 64'h0000_0000_0000_DEAD, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step();
      total_cnt++; if (bus.out_data !== 32'h7 || bus.out_hi !== 1'b0 || bus.out_last !== 1'b0)
        $display("FAIL stall_%0d got=%h/%b/%b exp=7/0/0", i, bus.out_data, bus.out_hi, bus.out_last); else pass_cnt++;
    end
    drive_idle();
    total_cnt++; if (count !== 2'd2) $display("FAIL refused_count got=%0d exp=2", count); else pass_cnt++;
    bus.out_ready = 1'b1;
    step();
    total_cnt++; if (bus.out_data !== 32'h3 || bus.out_hi !== 1'b1 || bus.out_last !== 1'b1)
      $display("FAIL div_hi got=%h/%b/%b exp=3/1/1", bus.out_data, bus.out_hi, bus.out_last); else pass_cnt++;
    // Still full while the HI beat pops: this push must be refused.
    drive_push(4'b0000, 64'h0000_0000_0000_0055, 1'b0);
    step();
    drive_idle();
    total_cnt++; if (count !== 2'd1) $display("FAIL full_pop_push_count got=%0d exp=1", count); else pass_cnt++;
    total_cnt++; if (bus.out_data !== 32'h0 || bus.out_zero !== 1'b1 || bus.out_last !== 1'b1)
      $display("FAIL or_beat got=%h/z%b/l%b exp=0/z1/l1", bus.out_data, bus.out_zero, bus.out_last); else pass_cnt++;
    step();
    total_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL bp_drained got=%b exp=0", bus.out_valid); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    bus.out_ready = 1'b1;
    drive_push(4'b0000, 64'd100, 1'b0);
    step();
    for (int i = 0; i < 8; i++) begin
      drive_push(4'b0000, 64'd101 + 64'(i), 1'b0);
      total_cnt++; if (bus.out_data !== 32'd100 + 32'(i) || count !== 2'd1)
        $display("FAIL stream_%0d got=%0d/c%0d exp=%0d/c1", i, bus.out_data, count, 100 + i); else pass_cnt++;
      step();
    end
    drive_idle();
    total_cnt++; if (bus.out_data !== 32'd108 || count !== 2'd1)
      $display("FAIL stream_tail got=%0d/c%0d exp=108/c1", bus.out_data, count); else pass_cnt++;
    step();
    total_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL stream_drained got=%b exp=0", bus.out_valid); else pass_cnt++;
  endtask

  task automatic test_reset_mid_hi();
    bus.out_ready = 1'b1;
    drive_push(4'b0111, 64'h0000_00AA_0000_00BB, 1'b0);
    step();
    drive_idle();
    total_cnt++; if (bus.out_data !== 32'hBB) $display("FAIL midrst_lo got=%h exp=bb", bus.out_data); else pass_cnt++;
    step();
    total_cnt++; if (bus.out_data !== 32'hAA || bus.out_hi !== 1'b1) $display("FAIL midrst_hi got=%h/%b exp=aa/1", bus.out_data, bus.out_hi); else pass_cnt++;
    bus.out_ready = 1'b0;
    clear = 1'b1;
    #1;
    total_cnt++; if (bus.out_valid !== 1'b0 || count !== 2'd0)
      $display("FAIL midrst_async got=v%b/c%0d exp=v0/c0", bus.out_valid, count); else pass_cnt++;
    step();
    clear = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      total_cnt++; if (bus.out_valid !== 1'b0 || dbg_beat !== 1'b0)
        $display("FAIL midrst_after_%0d got=v%b/b%b exp=v0/b0", i, bus.out_valid, dbg_beat); else pass_cnt++;
    end
  endtask

  task automatic test_zero_flag();
    bus.out_ready = 1'b1;
    drive_push(4'b0001, 64'h0, 1'b1);
    step();
    drive_push(4'b0001, 64'h1, 1'b0);
    total_cnt++; if (bus.out_zero !== 1'b1 || bus.out_data !== 32'h0)
      $display("FAIL zero_set got=z%b/%h exp=z1/0", bus.out_zero, bus.out_data); else pass_cnt++;
    step();
    drive_idle();
    total_cnt++; if (bus.out_zero !== 1'b0 || bus.out_data !== 32'h1)
      $display("FAIL zero_clr got=z%b/%h exp=z0/1", bus.out_zero, bus.out_data); else pass_cnt++;
    step();
    total_cnt++; if (count !== 2'd0) $display("FAIL zero_drained got=%0d exp=0", count); else pass_cnt++;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    bus.out_ready = 1'b0;
    drive_idle();
    test_reset();
    test_single_beat();
    test_multiply();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_hi();
    test_zero_flag();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/alu_result_drain.md
Name: alu_result_drain

Overview:
- Consumer-side unit for ALU results.
- Accepts a 64-bit result, zero flag and 4-bit opcode per transaction into a small FIFO.
- Drains each result onto the 32-bit datapath bus through a valid/ready handshake.
- Multiply (4'b0111) and divide (4'b1010) results go out as two beats, LO then HI. All other opcodes go out as one LO beat.
- Sits between the ALU output and the register-file / Z-register writeback path.

Parameters:
- DEPTH, 2, number of buffered results; power of two, ≥2.
- PTR_W, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
- clock  in  1  single system clock, rising edge.
- clear  in  1  reset, asynchronous, active-high.
- in_valid  in  1  producer has a result this cycle.
- in_ready  out  1  buffer can accept a result (= not full).
- in_result  in  64  ALU result; [31:0] LO, [63:32] HI.
- in_zero  in  1  ALU zero flag for this result.
- in_op  in  4  ALU opcode that produced the result.
- out_valid  out  1  a beat is presented on out_data.
- out_ready  in  1  consumer accepts the presented beat.
- out_data  out  32  beat payload.
- out_hi  out  1  1 = HI half beat, 0 = LO half beat.
- out_last  out  1  final beat of the current result.
- out_zero  out  1  zero flag of the current result, held for all its beats.
- count  out  PTR_W+1  number of results held, including one partly drained.

Behaviour:
- Reset (clear=1, asynchronous):
  - Write pointer, read pointer, count and beat register go to 0.
  - Outputs: in_ready=1, out_valid=0, out_data=0, out_hi=0, out_last=0, out_zero=0, count=0.
  - Storage contents are don't-care.
- Reset mid-transfer: all buffered results and any pending HI beat are discarded. No beat appears after clear deasserts until a new push occurs.
- Push: on a rising edge with in_valid & in_ready, store {in_result, in_zero, in_op} at wptr, wptr+1 (modulo DEPTH), count+1.
- in_ready = (count != DEPTH). A push while full is not accepted, even if a pop occurs in the same cycle.
- Latency: a push into an empty buffer produces out_valid=1 on the next cycle. There is no combinational in->out path.
- out_valid = (count != 0). Head entry is the one at rptr. Wide means head op ∈ {0111, 1010}.
- Beat register (1 bit, 0 = LO pending, 1 = HI pending) selects the outputs:
  - out_data = beat ? head.HI : head.LO
  - out_hi = beat
  - out_last = !wide | beat
  - out_zero = head.zero
  - When out_valid=0, out_data, out_hi, out_last and out_zero are all driven 0.
- Handshake on a rising edge with out_valid & out_ready:
  - Wide head and beat=0: beat→1. No pop.
  - Otherwise: pop (rptr+1 modulo DEPTH, count−1), beat→0.
- While out_valid=1 and out_ready=0, all out_* signals hold stable.
- Simultaneous push and pop in one cycle: count is unchanged and both pointers advance.
- Pointer wrap: pointers roll over from DEPTH−1 to 0. Ordering is strict FIFO across the wrap.
- Non-wide opcodes, including undefined 1101–1111, are one beat carrying the LO half. The HI half is ignored.
- in_result, in_zero and in_op are sampled only at the push edge. Changes on them at other times have no effect.

Test Plan:
- Reset then single add: push op=0000, result=64'h0000_0000_0000_0005, zero=0, out_ready=1 → next cycle out_data=5, out_hi=0, out_last=1. One cycle later out_valid=0 and count=0.
- Multiply two-beat: push op=0111, result=64'h0000_0001_8000_0000 → beat1 out_data=32'h8000_0000, out_hi=0, out_last=0; beat2 out_data=32'h0000_0001, out_hi=1, out_last=1. count drops to 0 only after beat2.
- Backpressure/full with DEPTH=2: push divide result 64'h0000_0003_0000_0007 and OR result 0, out_ready=0 → in_ready=0 and count=2. A third push is refused. HI/LO data stays stable for 5 stall cycles. After release the order is 7, 3, 0, with out_zero=1 on the last beat.
- Simultaneous push/pop: keep count=1 with out_ready=1 and a push on every cycle for 8 cycles → count stays 1, pointers wrap, and the beats arrive in push order.
- Reset mid-HI: clear asserted after the LO beat of a multiply is accepted, before the HI beat → out_valid=0 and count=0 immediately. No HI beat appears after clear deasserts.
- Zero flag passthrough: push sub result 0 with in_zero=1 → out_zero=1 and out_data=0 on the beat. A following push of 64'h1 with zero=0 → out_zero=0.
